// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned multiply/divide unit beside the execute-stage ALU.
// MUL is shift-add (LSB first), DIV is restoring division (MSB first), one bit per cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_cnt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  // Multiplicand for MUL, divisor for DIV: only one of them is needed per operation.
  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quot_q;

  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

  assign accept    = start && ((state == S_IDLE) || (state == S_DONE)) &&
                     ((alu_cnt == OP_MUL) || (alu_cnt == OP_DIV));
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    mul_sum   = '0;
    prod_next = '0;
    rem_shift = '0;
    rem_diff  = '0;
    div_ge    = 1'b0;
    rem_next  = '0;
    quot_next = '0;

    // Upper half plus multiplicand keeps its carry in bit WIDTH, which shifts into the top.
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, operand_q} : '0);
    prod_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Trial subtraction; a set sign bit means the shifted remainder was below the divisor.
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, operand_q};
    div_ge    = ~rem_diff[WIDTH];
    rem_next  = div_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      operand_q   <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            cnt <= '0;
            if (alu_cnt == OP_MUL) begin
              operand_q <= a;
              prod_q    <= {{WIDTH{1'b0}}, b};
              state     <= S_MUL;
            end else if (b == '0) begin
              hi          <= a;
              lo          <= '1;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              operand_q <= b;
              rem_q     <= '0;
              quot_q    <= a;
              state     <= S_DIV;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_MUL: begin
          prod_q <= prod_next;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            hi          <= prod_next[2*WIDTH-1:WIDTH];
            lo          <= prod_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            state       <= S_DONE;
          end
        end

        S_DIV: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            hi          <= rem_next;
            lo          <= quot_next;
            div_by_zero <= 1'b0;
            state       <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized back-to-back
// traffic compared against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int         W      = 32;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    alu_cnt;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  // Last completed result as predicted by the model: {div_by_zero, hi, lo}.
  logic [2*W:0] last_res;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_cnt     (alu_cnt),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outcome vector layout: {done_seen, busy_cycles[7:0], div_by_zero, hi, lo}.
  function automatic logic [2*W+9:0] expect_vec(input logic [3:0] op, input logic [W-1:0] av,
                                                input logic [W-1:0] bv, input int skipped);
    logic [2*W-1:0] prod;
    logic [7:0]     bc;
    bc = 8'(W - skipped);
    if (op == OP_MUL) begin
      prod = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
      return {1'b1, bc, 1'b0, prod};
    end else if (bv == 0) begin
      return {1'b1, 8'd0, 1'b1, av, {W{1'b1}}};
    end else begin
      return {1'b1, bc, 1'b0, av % bv, av / bv};
    end
  endfunction

  // Must be called at a negedge; the accept edge is the next posedge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    start   = 1'b1;
    alu_cnt = op;
    a       = av;
    b       = bv;
    @(negedge clk);
    start   = 1'b0;
    alu_cnt = 4'($urandom);
    a       = $urandom;
    b       = $urandom;
  endtask

  // Samples at negedges until done; returns the outcome vector, done_seen=0 on timeout.
  task automatic grab(output logic [2*W+9:0] got);
    int bc;
    bit seen;
    bc   = 0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
    got = {seen, 8'(bc), div_by_zero, hi, lo};
  endtask

  task automatic run_and_compare(input string name, input logic [3:0] op,
                                 input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [2*W+9:0] got;
    logic [2*W+9:0] exp;
    exp = expect_vec(op, av, bv, 0);
    issue(op, av, bv);
    grab(got);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {seen,busy_cyc,dbz,hi,lo}=%h required=%h", name, got, exp);
    end
    last_res = exp[2*W:0];
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    start   = 1'b0;
    alu_cnt = 4'b0000;
    a       = '0;
    b       = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, div_by_zero, hi, lo} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got {busy,done,dbz,hi,lo}=%h required=0",
               {busy, done, div_by_zero, hi, lo});
    end
    rst      = 1'b0;
    last_res = '0;
    @(negedge clk);
  endtask

  task automatic test_mul_directed;
    run_and_compare("mul_7x6", OP_MUL, 32'd7, 32'd6);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_single_pulse: got done=%b busy=%b required done=0 busy=0", done, busy);
    end
    run_and_compare("mul_max_carry", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
  endtask

  task automatic test_div_directed;
    run_and_compare("div_100_7", OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    run_and_compare("div_5_9", OP_DIV, 32'd5, 32'd9);
    @(negedge clk);
    run_and_compare("div_max_by_1", OP_DIV, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
  endtask

  task automatic test_div_by_zero;
    run_and_compare("div_by_zero", OP_DIV, 32'h0000_1234, 32'd0);
    // Issued in the DONE cycle: back-to-back after the zero divide.
    run_and_compare("mul_clears_dbz", OP_MUL, 32'd3, 32'd3);
    @(negedge clk);
  endtask

  task automatic test_illegal;
    int events;
    events  = 0;
    start   = 1'b1;
    alu_cnt = 4'b0000;
    a       = $urandom;
    b       = $urandom;
    @(negedge clk);
    alu_cnt = 4'b0111;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy !== 1'b0 || done !== 1'b0) events++;
      @(negedge clk);
    end
    n_cmp++;
    if (events != 0) begin
      n_err++;
      $display("FAIL illegal_ignored: got %0d busy/done cycles required 0", events);
    end
    n_cmp++;
    if ({div_by_zero, hi, lo} !== last_res) begin
      n_err++;
      $display("FAIL illegal_hold: got {dbz,hi,lo}=%h required=%h", {div_by_zero, hi, lo}, last_res);
    end
  endtask

  task automatic test_overlap;
    logic [2*W+9:0] got;
    logic [2*W+9:0] exp;
    int             events;
    exp = expect_vec(OP_MUL, 32'h0001_2345, 32'h0000_6789, 6);
    issue(OP_MUL, 32'h0001_2345, 32'h0000_6789);
    repeat (5) @(negedge clk);
    start   = 1'b1;
    alu_cnt = OP_DIV;
    a       = 32'd100;
    b       = 32'd7;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    grab(got);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL overlap_ignored: got {seen,busy_cyc,dbz,hi,lo}=%h required=%h", got, exp);
    end
    last_res = exp[2*W:0];
    events   = 0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b0 || done !== 1'b0) events++;
      @(negedge clk);
    end
    n_cmp++;
    if (events != 0) begin
      n_err++;
      $display("FAIL overlap_no_queue: got %0d busy/done cycles required 0", events);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 16;
    logic [3:0]     ops [N];
    logic [W-1:0]   as  [N];
    logic [W-1:0]   bs  [N];
    logic [2*W+9:0] got;
    logic [2*W+9:0] exp;
    for (int i = 0; i < N; i++) begin
      ops[i] = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
      as[i]  = $urandom;
      case ($urandom_range(0, 5))
        0:       bs[i] = '0;
        1:       bs[i] = 32'($urandom_range(1, 255));
        2:       bs[i] = 32'hFFFF_FFFF;
        default: bs[i] = $urandom;
      endcase
    end
    issue(ops[0], as[0], bs[0]);
    for (int i = 0; i < N; i++) begin
      exp = expect_vec(ops[i], as[i], bs[i], 0);
      grab(got);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_op%0d: got {seen,busy_cyc,dbz,hi,lo}=%h required=%h", i, got, exp);
      end
      last_res = exp[2*W:0];
      if (i < N - 1) begin
        // Request raised during the DONE cycle; accepted on the edge leaving DONE.
        issue(ops[i+1], as[i+1], bs[i+1]);
        n_cmp++;
        if ((ops[i+1] == OP_DIV && bs[i+1] == 0) ? (done !== 1'b1 || busy !== 1'b0)
                                                 : (busy !== 1'b1)) begin
          n_err++;
          $display("FAIL b2b_no_gap%0d: got busy=%b done=%b right after accept", i + 1, busy, done);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int events;
    issue(OP_DIV, 32'hDEAD_BEEF, 32'h0000_0123);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, div_by_zero, hi, lo} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got {busy,done,dbz,hi,lo}=%h required=0",
               {busy, done, div_by_zero, hi, lo});
    end
    last_res = '0;
    @(negedge clk);
    start   = 1'b1;
    alu_cnt = OP_MUL;
    a       = 32'd5;
    b       = 32'd5;
    events  = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) events++;
    end
    n_cmp++;
    if (events != 0) begin
      n_err++;
      $display("FAIL reset_hold_accept: got %0d busy/done cycles under reset required 0", events);
    end
    rst    = 1'b0;
    start  = 1'b0;
    events = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) events++;
    end
    n_cmp++;
    if (events != 0 || {div_by_zero, hi, lo} !== last_res) begin
      n_err++;
      $display("FAIL reset_abort: got %0d busy/done cycles, {dbz,hi,lo}=%h required 0 cycles, %h",
               events, {div_by_zero, hi, lo}, last_res);
    end
    run_and_compare("mul_after_reset", OP_MUL, 32'd2, 32'd3);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_div_by_zero();
    test_illegal();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle unsigned multiply/divide unit that consumes the 4-bit ALU control code. It sits beside the single-cycle ALU in the execute stage. It accepts a start request only for the MUL (4'b1000) and DIV (4'b1001) codes and returns a double-width product or a quotient/remainder pair. The datapath stalls on `busy` and captures results on the `done` pulse.

## Interface
- `WIDTH`, default 32: operand width. `hi` and `lo` are each `WIDTH` bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled on a rising edge only when `busy`=0.
- `alu_cnt`  in  4: operation code. 4'b1000 is MUL, 4'b1001 is DIV; every other value is ignored.
- `a`  in  WIDTH: multiplicand or dividend. Latched when a request is accepted.
- `b`  in  WIDTH: multiplier or divisor. Latched when a request is accepted.
- `busy`  out  1: high while an iteration is in progress.
- `done`  out  1: one-cycle pulse; `hi`/`lo` are valid and new.
- `hi`  out  WIDTH: product upper half (MUL) or remainder (DIV).
- `lo`  out  WIDTH: product lower half (MUL) or quotient (DIV).
- `div_by_zero`  out  1: set at completion of a DIV with `b`=0; cleared at completion of any other operation.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Request acceptance:
  - A request is accepted on an edge where the state is IDLE or DONE, `start`=1 and `alu_cnt` is 1000 or 1001.
  - `start` with any other `alu_cnt` leaves the state unchanged.
  - `start` while in MUL or DIV is ignored; there is no queueing.
- On acceptance: latch `a` and `b`, clear the iteration counter, and go to MUL or DIV. `a`/`b` changes after acceptance have no effect.
- MUL uses unsigned shift-add, one multiplier bit per cycle, LSB first.
  - Accumulator is 2*WIDTH bits wide. The carry out of each add must be retained; no truncation.
  - Result is the full unsigned product: {hi, lo}.
- DIV uses unsigned restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits wide.
  - `lo` = floor(a/b), `hi` = a mod b.
- DIV with `b`=0 skips the iteration. It goes directly from the accept edge to DONE with `hi`=`a`, `lo`=all ones, `div_by_zero`=1.
- MUL/DIV → DONE after exactly WIDTH iterations; `hi`/`lo` load on that edge.
- DONE → IDLE on the next edge, unless a new request is accepted on that edge (back-to-back issue is allowed).
- `hi`, `lo` and `div_by_zero` hold their values until the next completion.
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter 0.
- Reset asserted mid-operation aborts it immediately; no `done` is ever produced for the aborted request.

## Timing
- Accept edge = E0.
- `busy`:
  - High from E0 through edge E_WIDTH, i.e. WIDTH cycles.
  - Low in IDLE and DONE. `busy` is a pure state decode: 1 exactly in MUL or DIV.
- `done`:
  - High for exactly one cycle, between E_WIDTH and E_WIDTH+1.
  - This gives a latency of WIDTH+1 edges from acceptance to the end of `done`.
  - `done` is a pure state decode: 1 exactly in DONE.
- Divide-by-zero: `done` is high between E0 and E1 and `busy` never rises.
- Back-to-back: a request accepted on the edge leaving DONE makes `busy` high in the next cycle with no idle gap.
- Result registers change only on the edge entering DONE, never during iteration.
- All outputs are registered or state-decoded; there are no combinational paths from inputs to outputs.

## Test plan
- MUL, WIDTH=32, a=7, b=6 → after 32 busy cycles, one `done` cycle with `hi`=0, `lo`=42, `div_by_zero`=0.
- MUL, a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Checks the carry path. Then random a/b against a 64-bit reference model, with back-to-back starts issued in DONE cycles.
- DIV, a=100, b=7 → `lo`=14, `hi`=2. Then a=5, b=9 → `lo`=0, `hi`=5. Then a=0xFFFFFFFF, b=1 → `lo`=0xFFFFFFFF, `hi`=0.
- DIV, a=0x1234, b=0 → `done` in the cycle after the accept edge, `busy` never 1, `hi`=0x1234, `lo`=0xFFFFFFFF, `div_by_zero`=1. A following MUL 3*3 clears `div_by_zero` and gives `lo`=9.
- Illegal and overlapping requests:
  - `start` with `alu_cnt`=4'b0000 and then 4'b0111 → `busy` stays 0, no `done`, `hi`/`lo` unchanged.
  - During an active MUL, pulse `start` with DIV and change `a`/`b` → ignored; the original product is returned.
- Reset and hold:
  - Assert `rst` asynchronously at iteration 10 of a DIV → all outputs 0 immediately. No `done` follows; a new MUL 2*3 after release gives `lo`=6.
  - Hold `rst` high across multiple edges with `start`=1 → no acceptance.
